cal_sweep_seq: RTL
==================

CAL_SWEEP_SEQ -- requirements
Module: cal_sweep_seq

Interface
REQ-001 Parameter PARA_W, default 6, SHALL set the width of the calibration parameter.
REQ-002 Parameter DWELL_W, default 16, SHALL set the width of the dwell count.
REQ-003 clk_sys  input  1  SHALL be the system clock; all logic is rising-edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be a single-cycle sweep start request.
REQ-006 stop  input  1  SHALL be a single-cycle sweep abort request.
REQ-007 para_start  input  PARA_W  SHALL be the first sweep point.
REQ-008 para_end  input  PARA_W  SHALL be the last sweep point.
REQ-009 dwell  input  DWELL_W  SHALL be the number of clk_sys cycles between successive loads.
REQ-010 cal_load  output  1  SHALL be a one-cycle strobe marking a new point on cal_para.
REQ-011 cal_para  output  PARA_W  SHALL be the current calibration point, valid whenever cal_load is high.
REQ-012 busy  output  1  SHALL be high while a sweep is in progress.
REQ-013 done  output  1  SHALL be a one-cycle pulse when a sweep completes normally.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 The FSM SHALL have four states:
- IDLE
- LOAD (cal_load asserted)
- DWELL
- FINISH (done asserted)
REQ-016 In IDLE, when start is sampled high, the block SHALL latch para_start, para_end and dwell, and enter LOAD.
REQ-017 The first cal_load SHALL be high exactly one cycle after start is sampled, with cal_para equal to the latched para_start.
REQ-018 busy SHALL rise in the same cycle as the first cal_load.
REQ-019 Successive cal_load pulses SHALL be spaced exactly D cycles apart, where D = dwell, or D = 1 when dwell == 0.
REQ-020 The cal_load cycle SHALL count as the first of the D cycles.
REQ-021 When latched para_end >= para_start, cal_para SHALL step by +1 per load; otherwise it SHALL step by -1.
REQ-022 Sweep termination SHALL use an equality test against para_end, so cal_para never wraps past 0 or 2^PARA_W-1.
REQ-023 When para_start == para_end, the sweep SHALL issue exactly one cal_load.
REQ-024 D cycles after the final cal_load, the FSM SHALL enter FINISH: done high for one cycle, busy low in that same cycle, then return to IDLE.
REQ-025 Total cal_load pulses per sweep SHALL be |para_end - para_start| + 1.
REQ-026 start while busy SHALL be ignored.
REQ-027 Changes to para_start, para_end or dwell while busy SHALL be ignored.
REQ-028 stop sampled high in any non-IDLE state SHALL force IDLE on the next edge: busy low, no further cal_load, no done.
REQ-029 If stop and start are sampled high together in IDLE, stop SHALL win and no sweep SHALL start.
REQ-030 cal_para SHALL hold its last value after done or abort, until the next sweep's first load.

Reset
REQ-031 On rst_n low, the FSM SHALL enter IDLE immediately and asynchronously.
REQ-032 During reset, cal_load, busy and done SHALL be 0, cal_para SHALL be 0, and the dwell counter and latched inputs SHALL be 0.
REQ-033 Reset asserted mid-sweep SHALL abort the sweep without a done pulse.
REQ-034 After rst_n rises, the block SHALL wait for a fresh start.

Structure
REQ-035 Package cal_pkg SHALL hold the state encoding constants and the PARA_W and DWELL_W defaults.
REQ-036 The dwell counter SHALL be a sub-module cal_dwell_cnt: load D, count down, expire flag, clear on stop or reset.

Verification
REQ-037 Up sweep: start=2, end=5, dwell=4 -> four cal_load pulses at cycles 1, 5, 9, 13 after start, with cal_para 2, 3, 4, 5; done at cycle 17.
REQ-038 Down sweep: start=5, end=3, dwell=2 -> cal_para 5, 4, 3, pulses spaced 2 cycles; done once.
REQ-039 Edge values: start=end=63, dwell=0 -> one cal_load (cal_para=63), done 1 cycle later; and start=0, end=63, dwell=1 -> 64 back-to-back loads with no wrap.
REQ-040 Abort: stop asserted 1 cycle after the second cal_load of sweep 0->10, dwell=3 -> no further cal_load, no done, busy low next cycle, cal_para stays 1.
REQ-041 Reset mid-sweep: rst_n low during DWELL -> all outputs 0 asynchronously; a later start=7, end=7 -> single load of 7.
REQ-042 Ignore while busy: start pulse and para_end=0 change mid-sweep 1->4 -> sweep completes unchanged, 1..4.

Source files
------------

// File: rtl/cal_pkg.sv
// ---------------------------------------------------------------------------
// cal_pkg
// Shared definitions for the calibration sweep sequencer:
//   - default widths for the calibration parameter and the dwell count
//   - FSM state encoding used by cal_sweep_seq
// ---------------------------------------------------------------------------
package cal_pkg;

  localparam int unsigned CAL_PARA_W_DEF  = 6;
  localparam int unsigned CAL_DWELL_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // waiting for start
    ST_LOAD   = 2'd1,  // cal_load asserted, new point on cal_para
    ST_DWELL  = 2'd2,  // waiting out the remaining dwell cycles
    ST_FINISH = 2'd3   // done asserted for one cycle
  } cal_state_e;

endpackage

// File: rtl/cal_dwell_cnt.sv
// ---------------------------------------------------------------------------
// cal_dwell_cnt
// Down-counter that times the gap between successive calibration loads.
// The counter holds the number of cycles still to wait after the current
// one; expired_o is high when no further waiting is needed.
//
// Ports
//   clk_sys     : system clock, rising edge
//   rst_n       : asynchronous active-low reset, clears the count
//   clr_i       : synchronous clear (sweep abort / end of sweep)
//   load_i      : load load_val_i into the counter
//   load_val_i  : value to load (remaining wait cycles)
//   dec_i       : decrement by one (saturates at zero)
//   expired_o   : count is zero
// ---------------------------------------------------------------------------
module cal_dwell_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  // Clear has priority over load so an abort always leaves the counter idle.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/cal_sweep_seq.sv
// ---------------------------------------------------------------------------
// cal_sweep_seq
// Steps a calibration parameter from para_start to para_end (up or down by
// one per point), presenting each point on cal_para with a one-cycle
// cal_load strobe. Points are spaced D cycles apart, D = dwell (or 1 when
// dwell is 0). After the last point has dwelt D cycles, done pulses once.
// A stop request aborts the sweep immediately without a done pulse.
//
// Ports
//   clk_sys    : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : single-cycle sweep start request (ignored while sweeping)
//   stop       : single-cycle sweep abort request (wins over start)
//   para_start : first sweep point, latched at start
//   para_end   : last sweep point, latched at start
//   dwell      : cycles between loads, latched at start
//   cal_load   : one-cycle strobe, new point valid on cal_para
//   cal_para   : current calibration point (holds after sweep ends)
//   busy       : sweep in progress
//   done       : one-cycle pulse on normal sweep completion
// ---------------------------------------------------------------------------
module cal_sweep_seq
  import cal_pkg::*;
#(
  parameter int unsigned PARA_W  = CAL_PARA_W_DEF,
  parameter int unsigned DWELL_W = CAL_DWELL_W_DEF
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [PARA_W-1:0]  para_start,
  input  logic [PARA_W-1:0]  para_end,
  input  logic [DWELL_W-1:0] dwell,
  output logic               cal_load,
  output logic [PARA_W-1:0]  cal_para,
  output logic               busy,
  output logic               done
);

  cal_state_e         state_q;
  logic [PARA_W-1:0]  pstart_q;
  logic [PARA_W-1:0]  pend_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [PARA_W-1:0]  cal_para_q;
  logic               cal_load_q;
  logic               busy_q;
  logic               done_q;

  logic               cnt_clr;
  logic               cnt_load;
  logic               cnt_dec;
  logic [DWELL_W-1:0] cnt_load_val;
  logic               cnt_expired;

  logic [DWELL_W-1:0] dwell_m1_in;
  logic [DWELL_W-1:0] dwell_m1_q;
  logic               step_up;
  logic               last_point;
  logic [PARA_W-1:0]  next_para;

  // The load cycle itself is the first of the D cycles, so the counter is
  // loaded with D-1; dwell == 0 behaves like dwell == 1.
  always_comb begin
    dwell_m1_in = (dwell   == '0) ? '0 : dwell   - DWELL_W'(1);
    dwell_m1_q  = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
  end

  // Direction and termination come from the latched endpoints only, so
  // input changes mid-sweep have no effect. The equality test means the
  // sweep stops exactly on para_end and never wraps.
  always_comb begin
    step_up    = (pend_q >= pstart_q);
    last_point = (cal_para_q == pend_q);
    next_para  = step_up ? (cal_para_q + PARA_W'(1)) : (cal_para_q - PARA_W'(1));
  end

  // Dwell counter control, decoded from the current state and requests.
  always_comb begin
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = dwell_m1_q;
    case (state_q)
      ST_IDLE: begin
        if (!stop && start) begin
          cnt_load     = 1'b1;
          cnt_load_val = dwell_m1_in;  // latched copy not yet valid
        end
      end
      ST_LOAD, ST_DWELL: begin
        if (stop) begin
          cnt_clr = 1'b1;
        end else if (cnt_expired) begin
          if (!last_point) begin
            cnt_load = 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        cnt_clr = 1'b1;
      end
    endcase
  end

  cal_dwell_cnt #(
    .W (DWELL_W)
  ) u_dwell_cnt (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .expired_o  (cnt_expired)
  );

  // Sweep FSM with registered outputs. cal_load and done default low so
  // they can only ever be single-cycle pulses.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pstart_q   <= '0;
      pend_q     <= '0;
      dwell_q    <= '0;
      cal_para_q <= '0;
      cal_load_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cal_load_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // stop beats a simultaneous start
          if (!stop && start) begin
            pstart_q   <= para_start;
            pend_q     <= para_end;
            dwell_q    <= dwell;
            cal_para_q <= para_start;
            cal_load_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD, ST_DWELL: begin
          if (stop) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (cnt_expired) begin
            if (last_point) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_FINISH;
            end else begin
              cal_para_q <= next_para;
              cal_load_q <= 1'b1;
              state_q    <= ST_LOAD;
            end
          end else begin
            state_q <= ST_DWELL;
          end
        end
        ST_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cal_load = cal_load_q;
  assign cal_para = cal_para_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
